piso_frame_tx: RTL and testbench

PISO_FRAME_TX -- requirements
Module: piso_frame_tx

---
 rtl/piso_frame_tx_if.sv | 30 +++
 rtl/piso_frame_tx.sv | 94 +++++++++
 tb/tb_piso_frame_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_frame_tx_if.sv
// Handshake and line bundle for the framed PISO transmitter.
// master = word producer / line observer, slave = transmitter.
interface piso_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output serial_out,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_frame_tx.sv
// Framed PISO transmitter: start, WIDTH data bits LSB first,
// optional even parity, stop. Ports: clk, rst, bus (slave).
module piso_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  piso_frame_tx_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             ser_q, ser_d;
  logic             ready;
  logic             accept;

  assign ready  = !rst &&
                  (state_q == IDLE || state_q == STOP);
  assign accept = ready && bus.load_valid;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE, STOP: begin
        state_d = IDLE;
        if (accept) begin
          state_d = START;
          shift_d = bus.data_in;
          par_d   = ^bus.data_in;
          cnt_d   = '0;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      PARITY: state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Line value is registered from the next state so it
  // lines up with the state it belongs to.
  always_comb begin
    ser_d = 1'b1;
    unique case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = shift_d[0];
      PARITY:  ser_d = par_d;
      default: ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
    end
  end

  assign bus.load_ready = ready;
  assign bus.serial_out = ser_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == STOP);
endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: parity and no-parity instances
// checked every cycle against a queue-of-line-bits model.
module tb_piso_frame_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv  = 1'b0;
  logic [7:0] din = 8'h00;
  int         checks = 0;
  int         errors = 0;
  bit         armed  = 1'b0;

  always #5 clk = ~clk;

  piso_frame_tx_if #(.WIDTH(8)) bus_p ();
  piso_frame_tx_if #(.WIDTH(8)) bus_n ();

  assign bus_p.data_in    = din;
  assign bus_p.load_valid = lv;
  assign bus_n.data_in    = din;
  assign bus_n.load_valid = lv;

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(1)) dut_p (
    .clk (clk),
    .rst (rst),
    .bus (bus_p)
  );

  piso_frame_tx #(.WIDTH(8), .PARITY_EN(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  typedef struct packed {
    logic b;
    logic d;
  } ent_t;

  ent_t qp[$];
  ent_t qn[$];

  function automatic logic fbit(logic [7:0] d, int pe, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (pe != 0 && i == 9) return ^d;
    return 1'b1;
  endfunction

  // Each queue entry is the line bit for one future cycle.
  always @(posedge clk) begin
    logic acc_p;
    logic acc_n;
    ent_t e;
    acc_p = !rst && qp.size() <= 1 && lv;
    acc_n = !rst && qn.size() <= 1 && lv;
    if (rst) begin
      qp.delete();
      qn.delete();
      armed = 1'b1;
    end else begin
      if (qp.size() > 0) void'(qp.pop_front());
      if (qn.size() > 0) void'(qn.pop_front());
      if (acc_p)
        for (int i = 0; i < 11; i++) begin
          e.b = fbit(din, 1, i);
          e.d = (i == 10);
          qp.push_back(e);
        end
      if (acc_n)
        for (int i = 0; i < 10; i++) begin
          e.b = fbit(din, 0, i);
          e.d = (i == 9);
          qn.push_back(e);
        end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("p_serial", 32'(bus_p.serial_out),
          32'(qp.size() > 0 ? qp[0].b : 1'b1));
      chk("p_done", 32'(bus_p.done),
          32'(qp.size() > 0 ? qp[0].d : 1'b0));
      chk("p_busy", 32'(bus_p.busy), 32'(qp.size() > 0));
      chk("p_ready", 32'(bus_p.load_ready),
          32'(!rst && qp.size() <= 1));
      chk("n_serial", 32'(bus_n.serial_out),
          32'(qn.size() > 0 ? qn[0].b : 1'b1));
      chk("n_done", 32'(bus_n.done),
          32'(qn.size() > 0 ? qn[0].d : 1'b0));
      chk("n_busy", 32'(bus_n.busy), 32'(qn.size() > 0));
      chk("n_ready", 32'(bus_n.load_ready),
          32'(!rst && qn.size() <= 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap11(output logic [10:0] s,
                       output logic [10:0] d,
                       output logic [9:0]  sn,
                       output logic [9:0]  dn,
                       output logic        ball);
    ball = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s[i] = bus_p.serial_out;
      d[i] = bus_p.done;
      ball = ball & bus_p.busy;
      if (i < 10) begin
        sn[i] = bus_n.serial_out;
        dn[i] = bus_n.done;
      end
    end
    step();
  endtask

  logic [10:0] s, d;
  logic [9:0]  sn, dn;
  logic        ball;
  logic        c0d;

  initial begin
    lv  = 1'b1;
    din = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus_p.load_ready), 32'd0);
    chk("rst_serial", 32'(bus_p.serial_out), 32'd1);
    chk("rst_busy", 32'(bus_p.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lv  = 1'b0;
    step();

    din = 8'hB5;
    lv  = 1'b1;
    step();
    lv = 1'b0;
    cap11(s, d, sn, dn, ball);
    chk("b5_frame", 32'(s), 32'h76A);
    chk("b5_done", 32'(d), 32'h400);
    chk("b5_busy", 32'(ball), 32'd1);
    chk("b5_np_frame", 32'(sn), 32'h36A);
    chk("b5_np_done", 32'(dn), 32'h200);
    repeat (3) step();

    din = 8'h01;
    lv  = 1'b1;
    step();
    repeat (10) step();
    din = 8'hFF;
    @(negedge clk);
    c0d = bus_p.done;
    step();
    lv = 1'b0;
    cap11(s, d, sn, dn, ball);
    chk("b2b_stop", 32'(c0d), 32'd1);
    chk("b2b_frame", 32'(s), 32'h5FE);
    repeat (12) step();

    din = 8'h5A;
    lv  = 1'b1;
    step();
    lv = 1'b0;
    repeat (3) step();
    din = 8'h3C;
    lv  = 1'b1;
    step();
    lv = 1'b0;
    repeat (12) step();

    din = 8'hA5;
    lv  = 1'b1;
    step();
    lv  = 1'b0;
    din = 8'h00;
    cap11(s, d, sn, dn, ball);
    chk("hold_frame", 32'(s), 32'h54A);
    repeat (3) step();

    din = 8'hB5;
    lv  = 1'b1;
    step();
    lv = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    din = 8'h80;
    lv  = 1'b1;
    @(negedge clk);
    chk("abort_serial", 32'(bus_p.serial_out), 32'd1);
    chk("abort_busy", 32'(bus_p.busy), 32'd0);
    chk("abort_done", 32'(bus_p.done), 32'd0);
    chk("abort_ready", 32'(bus_p.load_ready), 32'd1);
    step();
    lv = 1'b0;
    cap11(s, d, sn, dn, ball);
    chk("post_rst_frame", 32'(s), 32'h700);
    repeat (3) step();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      lv  = ($urandom_range(0, 99) < 40);
      din = 8'($urandom);
      step();
    end
    rst = 1'b0;
    lv  = 1'b0;
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
